// File: rtl/nn_weight_update_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nn_weight_update_pkg
// Brief    : Shared types and constants for the weight-update training stage.
// Revision : 1.0 - initial release
// ============================================================================
package nn_weight_update_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      APPLY = 2'd2
   } state_t;

   localparam int c_NB_W_DEF = 8;
   localparam int c_W_MAX    = 2**(c_NB_W_DEF-1) - 1;
   localparam int c_W_MIN    = -c_W_MAX;

   // x^16 + x^14 + x^13 + x^11 + 1, bit 15 is tap 16
   localparam logic [15:0] c_LFSR_TAPS = 16'hB400;

   // Largest magnitude of a symmetric signed range of the given width
   function automatic int sym_limit(input int nb);
      return 2**(nb-1) - 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/nn_weight_update_if.sv
`default_nettype none
// ============================================================================
// Module   : nn_weight_update_if
// Brief    : Control, stochastic-input and weight-output bundle of the stage.
// Revision : 1.0 - initial release
// ============================================================================
interface nn_weight_update_if #(
   parameter int NB_W = 8
);
   logic            TRAIN;
   logic            LOAD;
   logic [NB_W-1:0] W_LOAD;
   logic            x;
   logic            zp;
   logic            e_pos;
   logic            e_neg;
   logic [NB_W-1:0] W;
   logic            w_pos;
   logic            w_neg;
   logic            APPLY_STB;

   modport master (
      output TRAIN, LOAD, W_LOAD, x, zp, e_pos, e_neg,
      input  W, w_pos, w_neg, APPLY_STB
   );

   modport slave (
      input  TRAIN, LOAD, W_LOAD, x, zp, e_pos, e_neg,
      output W, w_pos, w_neg, APPLY_STB
   );
endinterface
`default_nettype wire

// File: rtl/nn_wstream_gen.sv
`default_nettype none
// ============================================================================
// Module   : nn_wstream_gen
// Brief    : LFSR + magnitude comparator regenerating a signed weight as
//            sign-split stochastic bit streams (one cycle latency).
// Revision : 1.0 - initial release
// ============================================================================
module nn_wstream_gen
   import nn_weight_update_pkg::*;
#(
   parameter int          NB_W = 8,
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic            CLK,
   input  logic            INIT,
   input  logic [NB_W-1:0] W,
   output logic            w_pos,
   output logic            w_neg
);

   logic [15:0]     r_lfsr;
   logic            r_pos;
   logic            r_neg;
   logic            w_fb;
   logic            w_sign;
   logic [NB_W-2:0] w_mag;
   logic            w_bit;

   assign w_fb   = ^(r_lfsr & c_LFSR_TAPS);
   assign w_sign = W[NB_W-1];
   // W never holds the most-negative code, so |W| always fits NB_W-1 bits
   assign w_mag  = w_sign ? (~W[NB_W-2:0] + 1'b1) : W[NB_W-2:0];
   assign w_bit  = (r_lfsr[NB_W-2:0] < w_mag);

   always_ff @(posedge CLK or posedge INIT) begin
      if (INIT) begin
         r_lfsr <= SEED;
         r_pos  <= 1'b0;
         r_neg  <= 1'b0;
      end else begin
         r_lfsr <= {r_lfsr[14:0], w_fb};
         r_pos  <= w_bit & ~w_sign;
         r_neg  <= w_bit & w_sign;
      end
   end

   assign w_pos = r_pos;
   assign w_neg = r_neg;

endmodule
`default_nettype wire

// File: rtl/nn_weight_update.sv
`default_nettype none
// ============================================================================
// Module   : nn_weight_update
// Brief    : Epoch-based stochastic gradient accumulator with saturated,
//            scaled update of a signed weight and stochastic re-encoding.
// Revision : 1.0 - initial release
// ============================================================================
module nn_weight_update
   import nn_weight_update_pkg::*;
#(
   parameter int          NB_W      = 8,
   parameter int          NB_ACC    = 10,
   parameter int          EPOCH_LEN = 64,
   parameter int          LR_SHIFT  = 2,
   parameter logic [15:0] SEED      = 16'hACE1
) (
   input  logic           CLK,
   input  logic           INIT,
   nn_weight_update_if.slave bus
);

   localparam int c_NB_SUM  = ((NB_W > NB_ACC) ? NB_W : NB_ACC) + 1;
   localparam int c_NB_CNT  = (EPOCH_LEN > 1) ? $clog2(EPOCH_LEN) : 1;
   localparam int c_W_LIM   = sym_limit(NB_W);
   localparam int c_ACC_LIM = sym_limit(NB_ACC);

   localparam logic signed [c_NB_SUM-1:0] c_W_HI     = c_NB_SUM'(c_W_LIM);
   localparam logic signed [c_NB_SUM-1:0] c_W_LO     = -c_W_HI;
   localparam logic signed [NB_ACC-1:0]   c_ACC_HI   = NB_ACC'(c_ACC_LIM);
   localparam logic signed [NB_ACC-1:0]   c_ACC_LO   = -c_ACC_HI;
   localparam logic [c_NB_CNT-1:0]        c_CNT_LAST = c_NB_CNT'(EPOCH_LEN - 1);
   localparam logic [NB_W-1:0]            c_W_MNEG   = {1'b1, {(NB_W-1){1'b0}}};
   localparam logic [NB_W-1:0]            c_W_NLIM   = {1'b1, {(NB_W-2){1'b0}}, 1'b1};

   state_t                     r_state;
   state_t                     w_state_nxt;
   logic signed [NB_W-1:0]     r_w;
   logic signed [NB_ACC-1:0]   r_acc;
   logic [c_NB_CNT-1:0]        r_cnt;
   logic                       r_apply_stb;

   logic                       w_inc;
   logic                       w_dec;
   logic signed [NB_ACC-1:0]   w_acc_nxt;
   logic signed [NB_ACC-1:0]   w_delta;
   logic signed [c_NB_SUM-1:0] w_sum;
   logic [NB_W-1:0]            w_w_upd;
   logic [NB_W-1:0]            w_w_load;

   assign w_inc = bus.x & bus.zp & bus.e_pos;
   assign w_dec = bus.x & bus.zp & bus.e_neg;

   always_comb begin
      w_acc_nxt = r_acc;
      if (w_inc && !w_dec && (r_acc != c_ACC_HI))
         w_acc_nxt = r_acc + 1'b1;
      else if (w_dec && !w_inc && (r_acc != c_ACC_LO))
         w_acc_nxt = r_acc - 1'b1;
   end

   // Sum is formed one bit wider than either operand so clamping sees no wrap
   assign w_delta = r_acc >>> LR_SHIFT;
   assign w_sum   = {{(c_NB_SUM-NB_W){r_w[NB_W-1]}}, r_w}
                  + {{(c_NB_SUM-NB_ACC){w_delta[NB_ACC-1]}}, w_delta};
   assign w_w_upd = (w_sum > c_W_HI) ? c_W_HI[NB_W-1:0] :
                    (w_sum < c_W_LO) ? c_W_LO[NB_W-1:0] : w_sum[NB_W-1:0];
   assign w_w_load = (bus.W_LOAD == c_W_MNEG) ? c_W_NLIM : bus.W_LOAD;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (bus.TRAIN) w_state_nxt = ACCUM;
         ACCUM:   if (!bus.TRAIN)              w_state_nxt = IDLE;
                  else if (r_cnt == c_CNT_LAST) w_state_nxt = APPLY;
         APPLY:   w_state_nxt = bus.TRAIN ? ACCUM : IDLE;
         default: w_state_nxt = IDLE;
      endcase
      if (bus.LOAD) w_state_nxt = IDLE;
   end

   always_ff @(posedge CLK or posedge INIT) begin
      if (INIT) r_state <= IDLE;
      else      r_state <= w_state_nxt;
   end

   always_ff @(posedge CLK or posedge INIT) begin
      if (INIT) begin
         r_w         <= '0;
         r_acc       <= '0;
         r_cnt       <= '0;
         r_apply_stb <= 1'b0;
      end else begin
         r_apply_stb <= 1'b0;
         if (bus.LOAD) begin
            r_w   <= w_w_load;
            r_acc <= '0;
            r_cnt <= '0;
         end else begin
            case (r_state)
               ACCUM: begin
                  if (bus.TRAIN) begin
                     r_acc <= w_acc_nxt;
                     r_cnt <= r_cnt + 1'b1;
                  end else begin
                     r_acc <= '0;
                     r_cnt <= '0;
                  end
               end
               APPLY: begin
                  r_w         <= w_w_upd;
                  r_acc       <= '0;
                  r_cnt       <= '0;
                  r_apply_stb <= 1'b1;
               end
               default: begin
                  r_acc <= '0;
                  r_cnt <= '0;
               end
            endcase
         end
      end
   end

   logic w_pos_s;
   logic w_neg_s;

   nn_wstream_gen #(
      .NB_W (NB_W),
      .SEED (SEED)
   ) u_wstream_gen (
      .CLK   (CLK),
      .INIT  (INIT),
      .W     (r_w),
      .w_pos (w_pos_s),
      .w_neg (w_neg_s)
   );

   assign bus.W         = r_w;
   assign bus.APPLY_STB = r_apply_stb;
   assign bus.w_pos     = w_pos_s;
   assign bus.w_neg     = w_neg_s;

endmodule
`default_nettype wire

// File: doc/nn_weight_update.md
Name: nn_weight_update

Overview:
- Downstream training stage for the burst-gate derivative: consumes derivative stream zp, the forward input stream x and the sign-split error streams.
- Accumulates stochastic weight-gradient bits over a fixed epoch and applies a scaled, saturated update to a signed binary weight.
- Regenerates the weight as sign-split stochastic streams for the forward synapse multiplier, using an on-block LFSR and comparator.

Parameters:
NB_W, 8, signed weight width (two's complement)
NB_ACC, 10, signed gradient accumulator width
EPOCH_LEN, 64, cycles accumulated per update
LR_SHIFT, 2, learning-rate right shift applied to accumulator at update
SEED, 16'hACE1, LFSR reset seed (nonzero)

Ports:
CLK  in  1  clock, all state on rising edge
INIT  in  1  reset, asynchronous, active-high
TRAIN  in  1  enables accumulation/update
LOAD  in  1  synchronous weight load strobe
W_LOAD  in  NB_W  weight value for LOAD
x  in  1  forward input stochastic bit
zp  in  1  burst-gate derivative bit
e_pos  in  1  positive-error stochastic bit
e_neg  in  1  negative-error stochastic bit
W  out  NB_W  current signed weight
w_pos  out  1  stochastic weight stream, positive part
w_neg  out  1  stochastic weight stream, negative part
APPLY_STB  out  1  one-cycle pulse in the cycle W is updated

Behaviour:
- Clock CLK; reset INIT asynchronous active-high, as fixed for this block.
- INIT: W=0, acc=0, cnt=0, state=IDLE, w_pos=w_neg=0, APPLY_STB=0, LFSR=SEED. INIT mid-epoch discards the partial epoch.
- States: IDLE, ACCUM, APPLY.
  - IDLE -> ACCUM when TRAIN=1.
  - ACCUM -> IDLE when TRAIN=0; acc and cnt are cleared and the partial epoch is dropped.
  - ACCUM -> APPLY when cnt==EPOCH_LEN-1 with TRAIN=1.
  - APPLY -> ACCUM if TRAIN=1, else IDLE.
- ACCUM per cycle:
  - inc = x&zp&e_pos; dec = x&zp&e_neg.
  - inc&dec gives net 0.
  - acc += inc - dec, saturating at +/-(2^(NB_ACC-1)-1).
  - cnt increments by 1.
- APPLY (single cycle):
  - delta = acc >>> LR_SHIFT (arithmetic, rounds toward -inf).
  - W <= sat(W+delta) into [-(2^(NB_W-1)-1), +(2^(NB_W-1)-1)]. The most-negative code is never produced.
  - acc=0, cnt=0, APPLY_STB=1.
  - Input bits sampled in the APPLY cycle are discarded.
- LOAD has the highest synchronous priority in any state:
  - W <= W_LOAD, clamped to the symmetric range.
  - acc=0, cnt=0, state=IDLE, APPLY_STB=0.
  - LOAD during APPLY wins and the update is dropped.
- Stream generation, active in every state:
  - LFSR is 16-bit Fibonacci, taps 16,14,13,11, advances every CLK.
  - R = LFSR[NB_W-2:0]; bit = (R < |W|).
  - w_pos <= bit & ~W[NB_W-1]; w_neg <= bit & W[NB_W-1].
  - Registered: one cycle latency from W and LFSR to the stream outputs.
  - W=0 gives both streams constant 0; w_pos and w_neg are never high together.
- Width rule: W+delta is computed at max(NB_W,NB_ACC)+1 bits before clamping; there is no intermediate wrap.

Decomposition:
- Shared package constants:
  - Weight range limits W_MAX = 2^(NB_W-1)-1 and W_MIN = -W_MAX.
  - State encodings IDLE=2'd0, ACCUM=2'd1, APPLY=2'd2.
  - LFSR tap mask.
- One sub-module, nn_wstream_gen: LFSR plus magnitude comparator plus sign split, with its own CLK/INIT and SEED.
- Accumulator and FSM stay in the top level.

Test Plan:
- Reset/idle: assert INIT mid-run -> W=0, w_pos=w_neg=0, APPLY_STB=0 immediately. Release with TRAIN=0 for 200 cycles -> W stays 0, streams stay 0.
- Positive update: TRAIN=1, x=zp=e_pos=1, e_neg=0 for 64 ACCUM cycles -> acc=64, APPLY_STB pulses once, W 0->16. Next epoch W=32.
- Sign/rounding: e_neg=1 only for 3 of 64 cycles (x=zp=1) -> acc=-3, W 0->-1. inc and dec both high all epoch -> W unchanged.
- Saturation: LOAD W_LOAD=120, then one full positive epoch -> W=127. LOAD W_LOAD=-128 -> W=-127. One full negative epoch -> W stays -127.
- Mid-operation events: drop TRAIN at cnt=30 -> IDLE, no APPLY_STB, W unchanged. LOAD=1 coincident with APPLY -> W=W_LOAD, no APPLY_STB.
- Stream density: LOAD 64 -> w_pos ones over 4096 cycles = 2048 +/- 3%, w_neg=0. LOAD -32 -> w_neg density 0.25 +/- 3%, w_pos=0, never both high.
